// File: rtl/eth_pcs_pkg.sv
// Shared definitions for the 10GBASE-R style self-synchronising scrambler
// family, G(x) = 1 + x^39 + x^58.
package eth_pcs_pkg;

    localparam int W_SCR     = 58;
    localparam int SCR_TAP_A = 38;
    localparam int SCR_TAP_B = 57;

    typedef logic [W_SCR-1:0] scr_state_t;

    localparam scr_state_t SCR_SEED_DEFAULT = {W_SCR{1'b1}};

    typedef enum logic {
        SCR_TX = 1'b0,
        SCR_RX = 1'b1
    } scr_mode_e;

    // Number of set bits in a word of up to 64 bits (callers zero-pad).
    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c = c + 7'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_pcs_scr_step.sv
// One word of the x^58 + x^39 + 1 scrambler/descrambler, fully unrolled.
// Bit 0 of the word is the first bit on the wire and is processed first.
module eth_pcs_scr_step
    import eth_pcs_pkg::*;
#(
    parameter int        W_DATA = 32,
    parameter scr_mode_e MODE   = SCR_TX
) (
    input  scr_state_t        state,
    input  logic [W_DATA-1:0] data,
    output logic [W_DATA-1:0] data_out,
    output scr_state_t        next_state
);

    // Serial LFSR recurrence unrolled across the word; TX feeds back the
    // line bit it produced, RX feeds back the line bit it received.
    always_comb begin : step_loop
        scr_state_t s;
        logic       yb;
        s        = state;
        yb       = 1'b0;
        data_out = '0;
        for (int k = 0; k < W_DATA; k++) begin
            yb          = data[k] ^ s[SCR_TAP_A] ^ s[SCR_TAP_B];
            data_out[k] = yb;
            s           = {s[W_SCR-2:0], (MODE == SCR_RX) ? data[k] : yb};
        end
        next_state = s;
    end

endmodule

// File: rtl/eth_pcs_scr_param.sv
// Parametrised 10GBASE-R PCS scrambler / descrambler with valid handshake,
// per-word bypass, seed load and zero-data test-pattern generator/checker.
// One enabled clock of latency from i_data to o_data.
module eth_pcs_scr_param
    import eth_pcs_pkg::*;
#(
    parameter int         W_DATA   = 32,
    parameter int         SCR_MODE = 0,
    parameter scr_state_t SEED     = SCR_SEED_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_clk_en,
    input  logic              i_valid,
    input  logic [W_DATA-1:0] i_data,
    input  logic              i_bypass,
    input  logic              i_seed_load,
    input  scr_state_t        i_seed,
    input  logic              i_tp_en,
    input  logic              i_tp_clr,
    output logic              o_valid,
    output logic [W_DATA-1:0] o_data,
    output logic [15:0]       o_tp_err_cnt
);

    localparam scr_mode_e MODE = (SCR_MODE == 1) ? SCR_RX : SCR_TX;

    scr_state_t        state;
    scr_state_t        start_state;
    scr_state_t        next_state;
    logic [W_DATA-1:0] step_in;
    logic [W_DATA-1:0] step_out;
    logic [63:0]       step_out_ext;
    logic [6:0]        word_errs;
    logic              count_en;
    logic [15:0]       err_cnt;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [6:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {10'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // A seed load takes effect for the word arriving in the same cycle;
    // the TX test pattern is the scrambled all-zero stream.
    always_comb begin
        start_state  = i_seed_load ? i_seed : state;
        step_in      = (MODE == SCR_TX && i_tp_en) ? '0 : i_data;
        step_out_ext = '0;
        step_out_ext[W_DATA-1:0] = step_out;
        word_errs    = popcount64(step_out_ext);
        count_en     = (MODE == SCR_RX) && i_tp_en && i_valid && !i_bypass;
    end

    eth_pcs_scr_step #(
        .W_DATA (W_DATA),
        .MODE   (MODE)
    ) u_step (
        .state      (start_state),
        .data       (step_in),
        .data_out   (step_out),
        .next_state (next_state)
    );

    // Output stage: LFSR, output word and error counter all freeze while
    // the gearbox stalls, so a stalled stream equals a gapless one.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= SEED;
            o_valid <= 1'b0;
            o_data  <= '0;
            err_cnt <= '0;
        end else if (i_clk_en) begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_data <= i_bypass ? i_data : step_out;
            end
            if (i_valid && !i_bypass) begin
                state <= next_state;
            end else if (i_seed_load) begin
                state <= i_seed;
            end
            if (i_tp_clr) begin
                err_cnt <= '0;
            end else if (count_en) begin
                err_cnt <= sat_add16(err_cnt, word_errs);
            end
        end
    end

    // The checker exists only on the receive side.
    assign o_tp_err_cnt = (MODE == SCR_RX) ? err_cnt : 16'h0000;

endmodule

// File: tb/tb_eth_pcs_scr_param.sv
// Directed bench: scrambler/descrambler pairs at 16, 32 and 64 bits with a
// queue-based scoreboard driven from a bit-serial reference model.
module tb_eth_pcs_scr_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en, vld, byp, sl, tp, dtp, dclr, dsel, dvld;
    logic [31:0] data, flip, ddata;
    logic [63:0] wide;
    logic [57:0] seed;

    logic        s32_v, d32_v, s16_v, d16_v, s64_v, d64_v;
    logic [31:0] s32_d, d32_d;
    logic [15:0] s16_d, d16_d;
    logic [63:0] s64_d, d64_d;
    logic [15:0] s32_c, d32_c, s16_c, d16_c, s64_c, d64_c;
    logic        d32_in_v;
    logic [31:0] d32_in_d;

    int checks = 0;
    int failures = 0;

    logic [63:0] q_s32[$];
    logic [63:0] q_d32[$];
    logic [63:0] q_16[$];
    logic [63:0] q_64[$];
    logic [57:0] ms32;
    int          n_d32, n_16, n_64;
    logic        chk_d32;

    always #5 clk = ~clk;

    assign d32_in_v = dsel ? dvld : s32_v;
    assign d32_in_d = dsel ? ddata : (s32_d ^ flip);

    eth_pcs_scr_param #(.W_DATA(32), .SCR_MODE(0)) u_s32 (
        .i_clk(clk), .i_reset_n(rst_n), .i_clk_en(en), .i_valid(vld), .i_data(data),
        .i_bypass(byp), .i_seed_load(sl), .i_seed(seed), .i_tp_en(tp), .i_tp_clr(1'b0),
        .o_valid(s32_v), .o_data(s32_d), .o_tp_err_cnt(s32_c));

    eth_pcs_scr_param #(.W_DATA(32), .SCR_MODE(1), .SEED(58'h0)) u_d32 (
        .i_clk(clk), .i_reset_n(rst_n), .i_clk_en(en), .i_valid(d32_in_v), .i_data(d32_in_d),
        .i_bypass(1'b0), .i_seed_load(1'b0), .i_seed(seed), .i_tp_en(dtp), .i_tp_clr(dclr),
        .o_valid(d32_v), .o_data(d32_d), .o_tp_err_cnt(d32_c));

    eth_pcs_scr_param #(.W_DATA(16), .SCR_MODE(0)) u_s16 (
        .i_clk(clk), .i_reset_n(rst_n), .i_clk_en(en), .i_valid(vld), .i_data(wide[15:0]),
        .i_bypass(1'b0), .i_seed_load(1'b0), .i_seed(seed), .i_tp_en(1'b0), .i_tp_clr(1'b0),
        .o_valid(s16_v), .o_data(s16_d), .o_tp_err_cnt(s16_c));

    eth_pcs_scr_param #(.W_DATA(16), .SCR_MODE(1), .SEED(58'h0)) u_d16 (
        .i_clk(clk), .i_reset_n(rst_n), .i_clk_en(en), .i_valid(s16_v), .i_data(s16_d),
        .i_bypass(1'b0), .i_seed_load(1'b0), .i_seed(seed), .i_tp_en(1'b0), .i_tp_clr(1'b0),
        .o_valid(d16_v), .o_data(d16_d), .o_tp_err_cnt(d16_c));

    eth_pcs_scr_param #(.W_DATA(64), .SCR_MODE(0)) u_s64 (
        .i_clk(clk), .i_reset_n(rst_n), .i_clk_en(en), .i_valid(vld), .i_data(wide),
        .i_bypass(1'b0), .i_seed_load(1'b0), .i_seed(seed), .i_tp_en(1'b0), .i_tp_clr(1'b0),
        .o_valid(s64_v), .o_data(s64_d), .o_tp_err_cnt(s64_c));

    eth_pcs_scr_param #(.W_DATA(64), .SCR_MODE(1), .SEED(58'h0)) u_d64 (
        .i_clk(clk), .i_reset_n(rst_n), .i_clk_en(en), .i_valid(s64_v), .i_data(s64_d),
        .i_bypass(1'b0), .i_seed_load(1'b0), .i_seed(seed), .i_tp_en(1'b0), .i_tp_clr(1'b0),
        .o_valid(d64_v), .o_data(d64_d), .o_tp_err_cnt(d64_c));

    // Bit-serial reference scrambler: y = x ^ S[38] ^ S[57], S <= {S, y}.
    function automatic logic [63:0] mdl(input int w, inout logic [57:0] s, input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int k = 0; k < w; k++) begin
            y[k] = x[k] ^ s[38] ^ s[57];
            s    = {s[56:0], y[k]};
        end
        return y;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0; vld = 1'b0; byp = 1'b0; sl = 1'b0; tp = 1'b0;
        dtp = 1'b0; dclr = 1'b0; dsel = 1'b0; dvld = 1'b0;
        data = '0; flip = '0; ddata = '0; wide = '0; seed = '0;
        q_s32.delete(); q_d32.delete(); q_16.delete(); q_64.delete();
        ms32 = {58{1'b1}};
        n_d32 = 0; n_16 = 0; n_64 = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: push expectations for what is driven now, then check
    // whatever the DUTs emit after the edge.
    task automatic cyc();
        logic [57:0] st;
        logic [63:0] e;
        logic        was_en;
        logic [31:0] prev;
        if (en) begin
            if (vld) begin
                st = sl ? seed : ms32;
                if (byp) begin
                    e = {32'd0, data};
                end else begin
                    e = mdl(32, st, tp ? 64'd0 : {32'd0, data});
                end
                ms32 = st;
                q_s32.push_back(e);
                q_d32.push_back((tp && !byp) ? 64'd0 : {32'd0, data});
                q_16.push_back({48'd0, wide[15:0]});
                q_64.push_back(wide);
            end else if (sl) begin
                ms32 = seed;
            end
        end
        was_en = en;
        prev = s32_d;
        @(posedge clk);
        #1;
        if (was_en) begin
            if (s32_v) begin
                e = (q_s32.size() > 0) ? q_s32.pop_front() : 'x;
                chk("s32_data", {32'd0, s32_d}, e);
            end
            if (d32_v && !dsel && q_d32.size() > 0) begin
                e = q_d32.pop_front();
                if (chk_d32 && n_d32 >= 2) chk("loop32", {32'd0, d32_d}, e);
                n_d32++;
            end
            if (d16_v && q_16.size() > 0) begin
                e = q_16.pop_front();
                if (n_16 >= 4) chk("loop16", {48'd0, d16_d}, e);
                n_16++;
            end
            if (d64_v && q_64.size() > 0) begin
                e = q_64.pop_front();
                if (n_64 >= 1) chk("loop64", d64_d, e);
                n_64++;
            end
        end else begin
            chk("stall_hold", {32'd0, s32_d}, {32'd0, prev});
        end
    endtask

    task automatic rnd();
        data = $urandom;
        wide = {$urandom, $urandom};
    endtask

    initial begin
        logic [63:0] t;
        chk_d32 = 1'b1;
        do_reset();
        chk("rst_valid", {63'd0, s32_v}, 64'd0);
        chk("rst_data", {32'd0, s32_d}, 64'd0);
        chk("rst_cnt", {48'd0, d32_c}, 64'd0);

        // Known first words from the all-ones seed with zero data
        en = 1'b1; vld = 1'b1; data = '0;
        cyc();
        chk("w0_valid", {63'd0, s32_v}, 64'd1);
        chk("w0_data", {32'd0, s32_d}, 64'h0000_0000);
        cyc();
        chk("w1_data", {32'd0, s32_d}, 64'h03FF_FF80);

        // Gapless loopback at all three widths
        for (int i = 0; i < 1000; i++) begin
            rnd();
            cyc();
        end
        vld = 1'b0;
        repeat (3) cyc();

        // Random stalls and valid gaps
        for (int i = 0; i < 600; i++) begin
            en  = ($urandom_range(0, 9) >= 3);
            vld = ($urandom_range(0, 9) >= 3);
            rnd();
            cyc();
        end
        en = 1'b1; vld = 1'b0;
        repeat (3) cyc();

        // Bypass word inserted mid-stream
        chk_d32 = 1'b0;
        vld = 1'b1;
        repeat (4) begin rnd(); cyc(); end
        byp = 1'b1; data = 32'hA5A5_A5A5;
        cyc();
        chk("bypass_word", {32'd0, s32_d}, 64'hA5A5_A5A5);
        byp = 1'b0;
        repeat (4) begin rnd(); cyc(); end

        // Seed load with a word, alone, and with bypass
        t = {$urandom, $urandom};
        seed = t[57:0]; sl = 1'b1; rnd();
        cyc();
        sl = 1'b0;
        repeat (3) begin rnd(); cyc(); end
        t = {$urandom, $urandom};
        seed = t[57:0]; sl = 1'b1; vld = 1'b0;
        cyc();
        sl = 1'b0; vld = 1'b1;
        repeat (3) begin rnd(); cyc(); end
        t = {$urandom, $urandom};
        seed = t[57:0]; sl = 1'b1; byp = 1'b1; rnd();
        cyc();
        sl = 1'b0; byp = 1'b0;
        repeat (3) begin rnd(); cyc(); end

        // Test-pattern loopback: clear after sync, then one line error
        do_reset();
        en = 1'b1; vld = 1'b1; tp = 1'b1; dtp = 1'b1;
        repeat (3) begin rnd(); cyc(); end
        vld = 1'b0;
        repeat (3) cyc();
        dclr = 1'b1;
        cyc();
        dclr = 1'b0;
        chk("tp_clr", {48'd0, d32_c}, 64'd0);
        vld = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            rnd();
            cyc();
        end
        vld = 1'b0;
        repeat (3) cyc();
        chk("tp_clean", {48'd0, d32_c}, 64'd0);
        chk("tx_cnt_tied", {48'd0, s32_c}, 64'd0);
        vld = 1'b1;
        rnd(); cyc();
        flip = 32'h0000_0020;
        rnd(); cyc();
        flip = '0;
        repeat (4) begin rnd(); cyc(); end
        vld = 1'b0;
        repeat (3) cyc();
        chk("tp_one_flip", {48'd0, d32_c}, 64'd3);
        vld = 1'b1; dclr = 1'b1; flip = 32'h0000_0001;
        rnd(); cyc();
        chk("clr_priority", {48'd0, d32_c}, 64'd0);
        dclr = 1'b0; flip = '0; vld = 1'b0; tp = 1'b0; dtp = 1'b0;
        repeat (3) cyc();
        chk("cnt16_tied", {32'd0, s16_c, d16_c}, 64'd0);
        chk("cnt64_tied", {32'd0, s64_c, d64_c}, 64'd0);

        // Saturation: descrambler fed all ones from seed 0
        do_reset();
        en = 1'b1; vld = 1'b1; dsel = 1'b1; dvld = 1'b1; dtp = 1'b1;
        ddata = 32'hFFFF_FFFF;
        rnd(); cyc();
        rnd(); cyc();
        chk("sat_first2", {48'd0, d32_c}, 64'd45);
        for (int i = 0; i < 2100; i++) begin
            rnd();
            cyc();
        end
        chk("sat_value", {48'd0, d32_c}, 64'hFFFF);
        rnd(); cyc();
        chk("sat_hold", {48'd0, d32_c}, 64'hFFFF);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, s32_v}, 64'd0);
        chk("arst_data", {32'd0, s32_d}, 64'd0);
        chk("arst_cnt", {48'd0, d32_c}, 64'd0);
        do_reset();
        en = 1'b1; vld = 1'b1; data = '0;
        cyc();
        chk("rst_w0", {32'd0, s32_d}, 64'h0000_0000);
        cyc();
        chk("rst_w1", {32'd0, s32_d}, 64'h03FF_FF80);
        vld = 1'b0;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
